// File: rtl/alu_serial_nbit.sv
// Serial N-bit ALU (NOR/XOR/ADD/SUB): DIGIT bits per clock, LSB first, carry held between digits.
// Latency: out_valid rises NDIG cycles after the accept edge; one result per NDIG+2 cycles at best.
// Backpressure: result and flags held in DONE until out_ready; in_ready low outside IDLE, no queueing.
module alu_serial_nbit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);
    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] OP_NOR = 2'b00;
    localparam logic [1:0] OP_XOR = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;

    logic [DIGIT-1:0] da;
    logic [DIGIT-1:0] db;
    logic [DIGIT-1:0] dbx;
    logic [DIGIT:0]   sum;
    logic [DIGIT-1:0] res_dig;
    logic [WIDTH-1:0] r_next;
    logic             is_arith;
    logic             c_msb_in;
    logic             last;

    assign in_ready = (state == IDLE);

    always_comb begin
        da       = a_sh[DIGIT-1:0];
        db       = b_sh[DIGIT-1:0];
        is_arith = op_q[1];
        dbx      = (op_q == OP_SUB) ? ~db : db;
        sum      = {1'b0, da} + {1'b0, dbx} + {{DIGIT{1'b0}}, carry};
        // Carry into the top bit of the digit, recovered from the sum bit itself.
        c_msb_in = da[DIGIT-1] ^ dbx[DIGIT-1] ^ sum[DIGIT-1];
        case (op_q)
            OP_NOR:  res_dig = ~(da | db);
            OP_XOR:  res_dig = da ^ db;
            default: res_dig = sum[DIGIT-1:0];
        endcase
        r_next = (r_sh >> DIGIT) | (WIDTH'(res_dig) << (WIDTH - DIGIT));
        last   = (cnt == CNT_W'(NDIG - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            op_q      <= OP_NOR;
            a_sh      <= '0;
            b_sh      <= '0;
            r_sh      <= '0;
            s         <= '0;
            cout      <= 1'b0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        op_q  <= op;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> DIGIT;
                    b_sh <= b_sh >> DIGIT;
                    r_sh <= r_next;
                    cnt  <= cnt + CNT_W'(1);
                    if (is_arith) begin
                        carry <= sum[DIGIT];
                    end
                    if (last) begin
                        s         <= r_next;
                        zero      <= (r_next == '0);
                        cout      <= is_arith & sum[DIGIT];
                        ovf       <= is_arith & (c_msb_in ^ sum[DIGIT]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_serial_nbit.md
Name: alu_serial_nbit

Overview:
Multi-cycle N-bit ALU built as the sequential generalisation of the 1-bit ALU slice. It supports the same four operations (NOR, XOR, ADD, SUB) and processes DIGIT bits per clock, LSB first. A ripple carry is held in a register between digits. Operands enter through a valid/ready handshake; the result leaves through a second valid/ready handshake and carries status flags. The block sits between an operand source (register file or sequencer) and a result sink.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 2.
DIGIT, 1, bits processed per clock; must divide WIDTH. NDIG = WIDTH/DIGIT.

Ports:
clk  input  1  rising-edge clock, the only clock.
rst_n  input  1  synchronous reset, active-low.
in_valid  input  1  operand transaction offered.
in_ready  output  1  block can accept operands (high only in IDLE).
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in for ADD/SUB.
op  input  2  00 NOR, 01 XOR, 10 ADD, 11 SUB.
out_valid  output  1  result and flags valid.
out_ready  input  1  sink accepts result.
s  output  WIDTH  result.
cout  output  1  carry-out of MSB (arithmetic ops only).
zero  output  1  s == 0.
ovf  output  1  signed overflow (arithmetic ops only).

Behaviour:
- Reset: one clock is synchronous, rst_n low at a rising edge takes effect; all outputs are registered or state-decoded.
  - State goes to IDLE; s=0, cout=0, zero=0, ovf=0, out_valid=0, in_ready=1.
  - Digit counter=0 and carry register=0.
- States and transitions:
  - IDLE -> RUN on in_valid&&in_ready.
  - RUN -> DONE after NDIG digit cycles.
  - DONE -> IDLE on out_valid&&out_ready.
- IDLE accept edge: latch a, b, op and cin into internal registers; counter=0; carry=cin. Input changes after this edge have no effect on the transaction.
- RUN, each cycle: operate on the DIGIT LSBs of the A/B shift registers and shift the result digit into the top of the result register, so after NDIG cycles the result is LSB-aligned.
  - NOR: ~(a|b).
  - XOR: a^b.
  - ADD: a+b+carry.
  - SUB: a+~b+carry. cin=1 gives a-b; cin=0 gives a-b-1.
  - Carry updates only for ADD/SUB. Counter increments.
- Last RUN cycle (counter==NDIG-1): load s, cout, zero and ovf from the completed result and set out_valid=1.
  - cout = final carry (ADD/SUB), 0 for NOR/XOR.
  - ovf = carry into MSB XOR carry out of MSB (ADD/SUB), 0 for NOR/XOR.
  - zero = (s == 0) for all ops.
- Latency: out_valid is high exactly NDIG cycles after the accept edge.
- DONE: out_valid held at 1; s and flags held stable until the handshake edge, regardless of out_ready duration. in_ready=0, and in_valid is ignored.
- Handshake edge: out_valid -> 0 and state -> IDLE. s and flags keep their last values until the next result loads.
- Throughput: one transaction per NDIG+2 cycles minimum (accept, NDIG RUN, handshake).
- in_ready is 0 in RUN and DONE; no operand queueing.
- Reset mid-RUN or mid-DONE aborts the transaction: no out_valid is produced, and the next cycle is IDLE with in_ready=1.
- All arithmetic is modulo 2^WIDTH. Signed interpretation is two's complement.

Test Plan:
- WIDTH=8, DIGIT=1. ADD a=8'h3C, b=8'h0F, cin=0 -> s=8'h4B, cout=0, zero=0, ovf=0; out_valid rises exactly 8 cycles after the accept edge.
- ADD a=8'hFF, b=8'h01, cin=0 -> s=8'h00, cout=1, zero=1, ovf=0. Then ADD a=8'h7F, b=8'h01 -> s=8'h80, cout=0, ovf=1.
- SUB a=8'h05, b=8'h07, cin=1 -> s=8'hFE, cout=0, ovf=0. Then SUB a=8'h80, b=8'h01, cin=1 -> s=8'h7F, cout=1, ovf=1.
- NOR a=8'hF0, b=8'h0C -> s=8'h03, cout=0, ovf=0. XOR a=8'hA5, b=8'hFF -> s=8'h5A. Repeat with DIGIT=4: same results, latency 2 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1 and s/flags constant; in_ready=0; in_valid pulses ignored. Change a/b during RUN -> result unchanged.
- Drive rst_n=0 for one edge at RUN cycle 3 -> out_valid never asserts; in_ready=1 on the next cycle; a following ADD 8'h10+8'h20 gives s=8'h30.
